// File: rtl/pa_pkg.sv
// Shared PA-RISC core definitions: datapath widths, operand-handler selects,
// ALU opcodes and the writer-match helper used by the forwarding logic.
package pa_pkg;

  localparam int DW = 32;
  localparam int IW = 21;
  localparam int RW = 5;

  localparam logic [RW-1:0] GR0 = '0;

  typedef enum logic [2:0] {
    OH_RB    = 3'b000,
    OH_IMM11 = 3'b001,
    OH_IMM14 = 3'b010,
    OH_IMM21 = 3'b011,
    OH_SHR   = 3'b100,
    OH_SAR   = 3'b101,
    OH_SHL   = 3'b110
  } oh_sel_e;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_ANDCM = 4'h5;
  localparam logic [3:0] ALU_PASSB = 4'h6;
  localparam logic [3:0] ALU_CMP   = 4'h7;

  // GR0 is hardwired zero, so a write to it never forwards.
  function automatic logic writer_hits(input logic [RW-1:0] idx,
                                       input logic [RW-1:0] rd,
                                       input logic          we);
    return we && (idx != GR0) && (rd == idx);
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_fwd_select.sv
// Combinational forwarding mux: picks EX/MEM over MEM/WB data when the given
// source index matches an enabled writer, otherwise passes the default value.
module fwd_select
  import pa_pkg::*;
#(
  parameter int DW = pa_pkg::DW,
  parameter int RW = pa_pkg::RW
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] dflt,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [DW-1:0] mem_result,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] value
);

  always_comb begin
    value = dflt;
    if (writer_hits(idx, mem_rd, mem_we))
      value = mem_result;
    else if (writer_hits(idx, wb_rd, wb_we))
      value = wb_data;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with capture-time forwarding, operand refresh while
// stalled, and bubble insertion on flush.
module id_ex_stage_reg
  import pa_pkg::*;
#(
  parameter int DW = pa_pkg::DW,
  parameter int IW = pa_pkg::IW,
  parameter int RW = pa_pkg::RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_ra,
  input  logic [DW-1:0] id_rb,
  input  logic [RW-1:0] id_ra_idx,
  input  logic [RW-1:0] id_rb_idx,
  input  logic [IW-1:0] id_imm,
  input  logic [2:0]    id_sel,
  input  logic [3:0]    id_alu_op,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_we,
  input  logic          id_load,
  input  logic          id_store,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [DW-1:0] mem_result,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_ra,
  output logic [DW-1:0] ex_rb,
  output logic [RW-1:0] ex_ra_idx,
  output logic [RW-1:0] ex_rb_idx,
  output logic [IW-1:0] ex_imm,
  output logic [2:0]    ex_sel,
  output logic [3:0]    ex_alu_op,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_we,
  output logic          ex_load,
  output logic          ex_store
);

  logic [DW-1:0] ra_ld_p0, rb_ld_p0;
  logic [DW-1:0] ra_ref_p1, rb_ref_p1;
  logic [RW-1:0] ra_ref_idx_p1, rb_ref_idx_p1;

  // ID side: forward into the incoming operands.
  fwd_select #(.DW(DW), .RW(RW)) u_fwd_ld_a (
    .idx(id_ra_idx), .dflt(id_ra),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .value(ra_ld_p0)
  );

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_ld_b (
    .idx(id_rb_idx), .dflt(id_rb),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .value(rb_ld_p0)
  );

  // EX side: a bubble presents GR0 so it never picks up a writer's data.
  assign ra_ref_idx_p1 = ex_valid ? ex_ra_idx : GR0;
  assign rb_ref_idx_p1 = ex_valid ? ex_rb_idx : GR0;

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_ref_a (
    .idx(ra_ref_idx_p1), .dflt(ex_ra),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .value(ra_ref_p1)
  );

  fwd_select #(.DW(DW), .RW(RW)) u_fwd_ref_b (
    .idx(rb_ref_idx_p1), .dflt(ex_rb),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .value(rb_ref_p1)
  );

  // ID -> EX register boundary.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid  <= 1'b0;
      ex_ra     <= '0;
      ex_rb     <= '0;
      ex_ra_idx <= '0;
      ex_rb_idx <= '0;
      ex_imm    <= '0;
      ex_sel    <= OH_RB;
      ex_alu_op <= '0;
      ex_rd     <= '0;
      ex_reg_we <= 1'b0;
      ex_load   <= 1'b0;
      ex_store  <= 1'b0;
    end else if (stall) begin
      ex_ra <= ra_ref_p1;
      ex_rb <= rb_ref_p1;
    end else begin
      ex_valid  <= id_valid;
      ex_ra     <= (id_ra_idx == GR0) ? '0 : ra_ld_p0;
      ex_rb     <= (id_rb_idx == GR0) ? '0 : rb_ld_p0;
      ex_ra_idx <= id_ra_idx;
      ex_rb_idx <= id_rb_idx;
      ex_imm    <= id_imm;
      ex_sel    <= id_sel;
      ex_alu_op <= id_alu_op;
      ex_rd     <= id_rd;
      ex_reg_we <= id_valid & id_reg_we;
      ex_load   <= id_valid & id_load;
      ex_store  <= id_valid & id_store;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, capture, forwarding, GR0,
// stall refresh/hold and flush priority, with hand-computed expectations.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_ra, id_rb, mem_result, wb_data;
  logic [4:0]  id_ra_idx, id_rb_idx, id_rd, mem_rd, wb_rd;
  logic [20:0] id_imm;
  logic [2:0]  id_sel;
  logic [3:0]  id_alu_op;
  logic        id_reg_we, id_load, id_store, mem_we, wb_we;
  logic        ex_valid, ex_reg_we, ex_load, ex_store;
  logic [31:0] ex_ra, ex_rb;
  logic [4:0]  ex_ra_idx, ex_rb_idx, ex_rd;
  logic [20:0] ex_imm;
  logic [2:0]  ex_sel;
  logic [3:0]  ex_alu_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_imm(id_imm),
    .id_sel(id_sel), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_load(id_load), .id_store(id_store),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ra(ex_ra), .ex_rb(ex_rb),
    .ex_ra_idx(ex_ra_idx), .ex_rb_idx(ex_rb_idx), .ex_imm(ex_imm),
    .ex_sel(ex_sel), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_load(ex_load), .ex_store(ex_store)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_ra = '0; id_rb = '0; id_ra_idx = '0; id_rb_idx = '0;
    id_imm = '0; id_sel = '0; id_alu_op = '0; id_rd = '0;
    id_reg_we = 0; id_load = 0; id_store = 0;
    mem_rd = '0; mem_we = 0; mem_result = '0;
    wb_rd = '0; wb_we = 0; wb_data = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_rb", ex_rb, 32'h0);
    chk("rst_sel", {29'b0, ex_sel}, 32'h0);
    chk("rst_reg_we", {31'b0, ex_reg_we}, 32'h0);

    // Reset mid-stream, together with stall.
    idle();
    id_valid = 1; id_rb_idx = 5'd2; id_rb = 32'hDEADBEEF; id_sel = 3'b011;
    id_reg_we = 1; id_rd = 5'd12; id_imm = 21'h1ABCD;
    step();
    chk("pre_rst_rb", ex_rb, 32'hDEADBEEF);
    chk("pre_rst_imm", {11'b0, ex_imm}, 32'h1ABCD);
    reset = 1; stall = 1;
    step();
    chk("mid_rst_rb", ex_rb, 32'h0);
    chk("mid_rst_sel", {29'b0, ex_sel}, 32'h0);
    chk("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("mid_rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("mid_rst_imm", {11'b0, ex_imm}, 32'h0);

    // Plain capture, no writers.
    idle();
    id_valid = 1; id_rb_idx = 5'd3; id_rb = 32'h842FFFEB; id_sel = 3'b101;
    id_alu_op = 4'h5; id_rd = 5'd9; id_reg_we = 1;
    id_ra_idx = 5'd1; id_ra = 32'h0BADF00D;
    step();
    chk("cap_rb", ex_rb, 32'h842FFFEB);
    chk("cap_ra", ex_ra, 32'h0BADF00D);
    chk("cap_sel", {29'b0, ex_sel}, 32'h5);
    chk("cap_valid", {31'b0, ex_valid}, 32'h1);
    chk("cap_alu_op", {28'b0, ex_alu_op}, 32'h5);
    chk("cap_rd", {27'b0, ex_rd}, 32'd9);
    chk("cap_reg_we", {31'b0, ex_reg_we}, 32'h1);
    chk("cap_rb_idx", {27'b0, ex_rb_idx}, 32'd3);

    // Forward precedence: EX/MEM beats MEM/WB.
    idle();
    id_valid = 1; id_rb_idx = 5'd7; id_rb = 32'h33; id_ra_idx = 5'd8; id_ra = 32'h44;
    mem_we = 1; mem_rd = 5'd7; mem_result = 32'h11;
    wb_we = 1; wb_rd = 5'd7; wb_data = 32'h22;
    step();
    chk("fwd_mem_rb", ex_rb, 32'h11);
    chk("fwd_nomatch_ra", ex_ra, 32'h44);
    mem_we = 0;
    step();
    chk("fwd_wb_rb", ex_rb, 32'h22);
    wb_we = 0;
    step();
    chk("fwd_none_rb", ex_rb, 32'h33);

    // GR0 is never forwarded and always reads zero.
    idle();
    id_valid = 1; id_ra_idx = 5'd0; id_ra = 32'h55;
    mem_we = 1; mem_rd = 5'd0; mem_result = 32'h99;
    step();
    chk("gr0_ra", ex_ra, 32'h0);

    // id_valid=0 captures a bubble with controls suppressed.
    idle();
    id_valid = 0; id_reg_we = 1; id_load = 1; id_store = 1; id_rd = 5'd6;
    step();
    chk("inv_valid", {31'b0, ex_valid}, 32'h0);
    chk("inv_reg_we", {31'b0, ex_reg_we}, 32'h0);
    chk("inv_load", {31'b0, ex_load}, 32'h0);
    chk("inv_store", {31'b0, ex_store}, 32'h0);

    // Stall refresh from WB, then from MEM over WB.
    idle();
    id_valid = 1; id_rb_idx = 5'd4; id_rb = 32'hAAAA; id_ra_idx = 5'd6; id_ra = 32'h6666;
    id_rd = 5'd10; id_sel = 3'b001; id_reg_we = 1; id_load = 1;
    step();
    chk("stl_pre_rb", ex_rb, 32'hAAAA);
    idle();
    stall = 1; id_valid = 1; id_rb = 32'hBBBB; id_sel = 3'b110; id_rd = 5'd20;
    wb_we = 1; wb_rd = 5'd4; wb_data = 32'h1234;
    step();
    chk("stl_ref_rb", ex_rb, 32'h1234);
    chk("stl_ref_ra", ex_ra, 32'h6666);
    chk("stl_ref_sel", {29'b0, ex_sel}, 32'h1);
    chk("stl_ref_rd", {27'b0, ex_rd}, 32'd10);
    chk("stl_ref_load", {31'b0, ex_load}, 32'h1);
    wb_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_hold_rb", ex_rb, 32'h1234);
      chk("stl_hold_ra", ex_ra, 32'h6666);
      chk("stl_hold_sel", {29'b0, ex_sel}, 32'h1);
      chk("stl_hold_valid", {31'b0, ex_valid}, 32'h1);
    end
    mem_we = 1; mem_rd = 5'd6; mem_result = 32'h77;
    wb_we = 1; wb_rd = 5'd6; wb_data = 32'h88;
    step();
    chk("stl_mem_ra", ex_ra, 32'h77);
    chk("stl_mem_rb", ex_rb, 32'h1234);

    // Flush wins over stall.
    idle();
    stall = 1; flush = 1; id_valid = 1; id_reg_we = 1; id_store = 1; id_rd = 5'd3;
    step();
    chk("fl_valid", {31'b0, ex_valid}, 32'h0);
    chk("fl_reg_we", {31'b0, ex_reg_we}, 32'h0);
    chk("fl_store", {31'b0, ex_store}, 32'h0);
    chk("fl_rd", {27'b0, ex_rd}, 32'h0);
    chk("fl_ra", ex_ra, 32'h0);

    // Stalled bubble does not pick up writer data.
    idle();
    stall = 1; mem_we = 1; mem_rd = 5'd0; mem_result = 32'h5A5A;
    step();
    chk("bub_stl_ra", ex_ra, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
